// File: rtl/flash_seq.sv
// flash_seq: programmable ON/OFF blink sequencer paced by the flash timebase
// strobe. It accepts one command (ON length, OFF length, repeat count) over
// a valid/ready handshake, drives flash_on for the commanded number of
// cycles, and pulses done on normal completion. abort cancels a sequence.
module flash_seq #(
  parameter int LEN_W = 8,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_nxt,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] on_len,
  input  logic [LEN_W-1:0] off_len,
  input  logic [REP_W-1:0] reps,
  input  logic             abort,
  output logic             flash_on,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] rep_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

  state_t           r_state, w_next;
  logic [LEN_W-1:0] r_on_len, w_on_len;
  logic [LEN_W-1:0] r_off_len, w_off_len;
  logic [REP_W-1:0] r_reps, w_reps;
  logic [LEN_W-1:0] r_phase, w_phase;
  logic [REP_W-1:0] r_rep_cnt, w_rep_cnt;
  logic             r_cmd_ready, r_flash_on, r_busy, r_done;

  // End of an ON/OFF cycle: either the last repeat (go to DONE) or start
  // the next ON phase. rep_cnt wraps freely for the endless (reps==0) mode.
  function automatic void cycle_complete(
    input  logic [REP_W-1:0] cur_rep,
    input  logic [REP_W-1:0] lat_reps,
    output state_t           nxt,
    output logic [REP_W-1:0] nxt_rep
  );
    if ((lat_reps != '0) && (cur_rep == lat_reps - REP_ONE)) begin
      nxt     = S_DONE;
      nxt_rep = lat_reps;
    end else begin
      nxt     = S_ON;
      nxt_rep = cur_rep + REP_ONE;
    end
  endfunction

  // Next-state and next-value logic for state, latched command and counters
  always_comb begin
    w_next    = r_state;
    w_on_len  = r_on_len;
    w_off_len = r_off_len;
    w_reps    = r_reps;
    w_phase   = r_phase;
    w_rep_cnt = r_rep_cnt;
    case (r_state)
      S_IDLE: begin
        // abort is meaningless in IDLE, so a coincident command still wins
        if (cmd_valid) begin
          w_on_len  = on_len;
          w_off_len = off_len;
          w_reps    = reps;
          w_phase   = '0;
          w_rep_cnt = '0;
          w_next    = (on_len == '0) ? S_DONE : S_ON;
        end
      end
      S_ON: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (en_nxt) begin
          if (r_phase == r_on_len - LEN_ONE) begin
            w_phase = '0;
            if (r_off_len != '0) begin
              w_next = S_OFF;
            end else begin
              cycle_complete(r_rep_cnt, r_reps, w_next, w_rep_cnt);
            end
          end else begin
            w_phase = r_phase + LEN_ONE;
          end
        end
      end
      S_OFF: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (en_nxt) begin
          if (r_phase == r_off_len - LEN_ONE) begin
            w_phase = '0;
            cycle_complete(r_rep_cnt, r_reps, w_next, w_rep_cnt);
          end else begin
            w_phase = r_phase + LEN_ONE;
          end
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State, command latch and counters; outputs registered from next state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_on_len    <= '0;
      r_off_len   <= '0;
      r_reps      <= '0;
      r_phase     <= '0;
      r_rep_cnt   <= '0;
      r_cmd_ready <= 1'b1;
      r_flash_on  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_on_len    <= w_on_len;
      r_off_len   <= w_off_len;
      r_reps      <= w_reps;
      r_phase     <= w_phase;
      r_rep_cnt   <= w_rep_cnt;
      r_cmd_ready <= (w_next == S_IDLE);
      r_flash_on  <= (w_next == S_ON);
      r_busy      <= (w_next == S_ON) || (w_next == S_OFF);
      r_done      <= (w_next == S_DONE);
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign flash_on  = r_flash_on;
  assign busy      = r_busy;
  assign done      = r_done;
  assign rep_cnt   = r_rep_cnt;

endmodule

// File: tb/tb_flash_seq.sv
// Testbench for flash_seq: a tick-countdown reference model feeds an
// expected-output queue every clock, plus a command table with hand-derived
// totals and directed sequences for abort, handshake and reset.
module tb_flash_seq;
  localparam int LEN_W = 8;
  localparam int REP_W = 4;
  localparam int S_IDLE = 0, S_ON = 1, S_OFF = 2, S_DONE = 3;

  logic             clk = 1'b0;
  logic             reset, en_nxt, cmd_valid, abort;
  logic [LEN_W-1:0] on_len, off_len;
  logic [REP_W-1:0] reps;
  logic             cmd_ready, flash_on, busy, done;
  logic [REP_W-1:0] rep_cnt;

  flash_seq #(.LEN_W(LEN_W), .REP_W(REP_W)) dut (
    .clk(clk), .reset(reset), .en_nxt(en_nxt), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .on_len(on_len), .off_len(off_len), .reps(reps),
    .abort(abort), .flash_on(flash_on), .busy(busy), .done(done),
    .rep_cnt(rep_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             rdy;
    logic             bsy;
    logic             fl;
    logic             dn;
    logic [REP_W-1:0] rc;
  } exp_t;

  typedef struct {
    int on; int off; int rp; int period;
    int exp_ticks; int exp_on_ticks; int exp_rep;
  } vec_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model: counts remaining ticks of the current phase downwards
  int               m_st = S_IDLE;
  int               m_left = 0;
  logic [REP_W-1:0] m_cyc = '0;
  logic [LEN_W-1:0] m_on = '0, m_off = '0;
  logic [REP_W-1:0] m_reps = '0;

  task automatic m_finish_cycle();
    m_cyc = m_cyc + 1'b1;
    if (m_reps != 0 && m_cyc == m_reps) m_st = S_DONE;
    else begin
      m_st   = S_ON;
      m_left = int'(m_on);
    end
  endtask

  task automatic model_update();
    if (reset) begin
      m_st = S_IDLE; m_cyc = '0; m_left = 0;
    end else begin
      case (m_st)
        S_IDLE: if (cmd_valid) begin
          m_on = on_len; m_off = off_len; m_reps = reps; m_cyc = '0;
          if (on_len == 0) m_st = S_DONE;
          else begin m_st = S_ON; m_left = int'(on_len); end
        end
        S_ON: if (abort) m_st = S_IDLE;
          else if (en_nxt) begin
            m_left--;
            if (m_left == 0) begin
              if (m_off != 0) begin m_st = S_OFF; m_left = int'(m_off); end
              else m_finish_cycle();
            end
          end
        S_OFF: if (abort) m_st = S_IDLE;
          else if (en_nxt) begin
            m_left--;
            if (m_left == 0) m_finish_cycle();
          end
        default: m_st = S_IDLE;
      endcase
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // one clock: drive inputs, model the edge, queue expectation, compare
  task automatic step(input logic v, input logic e, input logic a, input logic r);
    exp_t ex, got;
    cmd_valid = v; en_nxt = e; abort = a; reset = r;
    @(posedge clk);
    model_update();
    ex.rdy = (m_st == S_IDLE);
    ex.bsy = (m_st == S_ON) || (m_st == S_OFF);
    ex.fl  = (m_st == S_ON);
    ex.dn  = (m_st == S_DONE);
    ex.rc  = m_cyc;
    sbq.push_back(ex);
    #1;
    cyc++;
    ex  = sbq.pop_front();
    got = {cmd_ready, busy, flash_on, done, rep_cnt};
    checks++;
    if (got !== ex) begin
      errors++;
      $display("FAIL cycle_%0d: got rdy=%b busy=%b flash=%b done=%b rep=%0d, expected rdy=%b busy=%b flash=%b done=%b rep=%0d",
               cyc, got.rdy, got.bsy, got.fl, got.dn, got.rc,
               ex.rdy, ex.bsy, ex.fl, ex.dn, ex.rc);
    end
  endtask

  // run an already-accepted sequence until done; count ticks issued
  task automatic run_to_done(input int period, input int maxc, input logic hold_v,
                             output int ticks, output int on_ticks);
    int k;
    logic e;
    ticks = 0; on_ticks = 0; k = 0;
    while (!done && k < maxc) begin
      e = ((k % period) == period - 1);
      if (e) begin
        ticks++;
        if (flash_on) on_ticks++;
      end
      step(hold_v, e, 1'b0, 1'b0);
      k++;
    end
    check("done_within_budget", int'(k < maxc), 1);
  endtask

  vec_t vt[5];
  int ticks, on_ticks, dones;

  initial begin
    vt[0] = '{on: 2, off: 1, rp: 2, period: 4, exp_ticks: 6, exp_on_ticks: 4, exp_rep: 2};
    vt[1] = '{on: 0, off: 5, rp: 3, period: 2, exp_ticks: 0, exp_on_ticks: 0, exp_rep: 0};
    vt[2] = '{on: 3, off: 0, rp: 2, period: 3, exp_ticks: 6, exp_on_ticks: 6, exp_rep: 2};
    vt[3] = '{on: 1, off: 2, rp: 3, period: 2, exp_ticks: 9, exp_on_ticks: 3, exp_rep: 3};
    vt[4] = '{on: 4, off: 3, rp: 1, period: 1, exp_ticks: 7, exp_on_ticks: 4, exp_rep: 1};

    on_len = '0; off_len = '0; reps = '0;
    cmd_valid = 0; en_nxt = 0; abort = 0; reset = 1;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_ready", int'(cmd_ready), 1);
    check("reset_flash", int'(flash_on), 0);
    check("reset_rep", int'(rep_cnt), 0);

    // table-driven commands
    for (int i = 0; i < 5; i++) begin
      on_len = LEN_W'(vt[i].on); off_len = LEN_W'(vt[i].off); reps = REP_W'(vt[i].rp);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check($sformatf("v%0d_flash_after_accept", i), int'(flash_on), int'(vt[i].on != 0));
      run_to_done(vt[i].period, 200, 1'b0, ticks, on_ticks);
      check($sformatf("v%0d_ticks", i), ticks, vt[i].exp_ticks);
      check($sformatf("v%0d_on_ticks", i), on_ticks, vt[i].exp_on_ticks);
      check($sformatf("v%0d_rep", i), int'(rep_cnt), vt[i].exp_rep);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("v%0d_ready_after_done", i), int'(cmd_ready), 1);
      check($sformatf("v%0d_rep_hold", i), int'(rep_cnt), vt[i].exp_rep);
    end

    // endless sequence, then abort coincident with a tick
    on_len = 1; off_len = 1; reps = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    dones = 0; on_ticks = 0;
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 1 && flash_on) on_ticks++;
      step(1'b0, (k % 2 == 1), 1'b0, 1'b0);
      if (done) dones++;
    end
    check("inf_no_done", dones, 0);
    check("inf_on_ticks", on_ticks, 10);
    check("inf_rep", int'(rep_cnt), 10);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("abort_ready", int'(cmd_ready), 1);
    check("abort_flash", int'(flash_on), 0);
    check("abort_done", int'(done), 0);
    check("abort_busy", int'(busy), 0);

    // command held while busy; accepted right after DONE, with a tick
    on_len = 2; off_len = 1; reps = 1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    on_len = 7; off_len = 7; reps = 5;
    run_to_done(2, 100, 1'b1, ticks, on_ticks);
    check("hold_old_ticks", ticks, 3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("hold_ready_after_done", int'(cmd_ready), 1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("hold_accepted", int'(busy), 1);
    ticks = 0;
    for (int k = 0; k < 20 && flash_on; k++) begin
      ticks++;
      step(1'b0, 1'b1, 1'b0, 1'b0);
    end
    check("new_on_len_ticks", ticks, 7);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // reset in the middle of ON with nonzero rep_cnt
    on_len = 1; off_len = 1; reps = 3;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
    check("pre_reset_rep", int'(rep_cnt), 1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_flash", int'(flash_on), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_rep", int'(rep_cnt), 0);
    on_len = 2;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("post_reset_accept", int'(flash_on), 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
